// File: rtl/regs_arb_if.sv
// regs_arb_if: register-bus bundle around the two-requester arbiter.
// Carries both requester ports (m0_*, m1_*) and the shared slave port (s_*).
//   master modport : the arbiter's view (consumes requests and slave responses,
//                    drives completions and the slave request).
//   slave  modport : the environment's view (requesters plus register file).
interface regs_arb_if #(
    parameter int ADDR_W = 10
);
    logic              m0_val;
    logic [ADDR_W-1:0] m0_addr;
    logic              m0_write;
    logic [31:0]       m0_wdata;
    logic [31:0]       m0_rdata;
    logic              m0_ready;
    logic              m0_err;

    logic              m1_val;
    logic [ADDR_W-1:0] m1_addr;
    logic              m1_write;
    logic [31:0]       m1_wdata;
    logic [31:0]       m1_rdata;
    logic              m1_ready;
    logic              m1_err;

    logic              s_val;
    logic [ADDR_W-1:0] s_addr;
    logic              s_write;
    logic [31:0]       s_wdata;
    logic [31:0]       s_rdata;
    logic              s_ready;

    modport master (
        input  m0_val, m0_addr, m0_write, m0_wdata,
        output m0_rdata, m0_ready, m0_err,
        input  m1_val, m1_addr, m1_write, m1_wdata,
        output m1_rdata, m1_ready, m1_err,
        output s_val, s_addr, s_write, s_wdata,
        input  s_rdata, s_ready
    );

    modport slave (
        output m0_val, m0_addr, m0_write, m0_wdata,
        input  m0_rdata, m0_ready, m0_err,
        output m1_val, m1_addr, m1_write, m1_wdata,
        input  m1_rdata, m1_ready, m1_err,
        input  s_val, s_addr, s_write, s_wdata,
        output s_rdata, s_ready
    );
endinterface

// File: rtl/regs_arb.sv
// regs_arb: round-robin arbiter sharing one register-bus slave port between
// the host control path (m0) and the network command path (m1), with a
// response timeout so a hung slave cannot stall either requester.
// Ports:
//   clk     - rising-edge clock
//   rstn    - asynchronous active-low reset
//   bus     - regs_arb_if.master: m0_*/m1_* requester ports, s_* slave port
//   busy    - high while a transaction is outstanding or completing
//   gnt     - index of the requester currently or last granted
//   tmo_cnt - saturating count of timed-out transactions
module regs_arb #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rstn,
    regs_arb_if.master bus,
    output logic       busy,
    output logic       gnt,
    output logic [15:0] tmo_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    logic              last;
    logic [7:0]        timer;

    logic              any_req;
    logic              pick;
    logic [ADDR_W-1:0] pick_addr;
    logic              pick_write;
    logic [31:0]       pick_wdata;

    // On a tie the requester that did not win last time is chosen; otherwise
    // whichever single requester is asserting.
    always_comb begin
        any_req = bus.m0_val | bus.m1_val;
        if (bus.m0_val && bus.m1_val) begin
            pick = ~last;
        end else begin
            pick = bus.m1_val;
        end
        pick_addr  = pick ? bus.m1_addr  : bus.m0_addr;
        pick_write = pick ? bus.m1_write : bus.m0_write;
        pick_wdata = pick ? bus.m1_wdata : bus.m0_wdata;
    end

    assign busy = (state == REQ) || (state == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            last         <= 1'b1;
            timer        <= 8'd0;
            gnt          <= 1'b0;
            tmo_cnt      <= 16'd0;
            bus.s_val    <= 1'b0;
            bus.s_addr   <= '0;
            bus.s_write  <= 1'b0;
            bus.s_wdata  <= 32'd0;
            bus.m0_rdata <= 32'd0;
            bus.m0_ready <= 1'b0;
            bus.m0_err   <= 1'b0;
            bus.m1_rdata <= 32'd0;
            bus.m1_ready <= 1'b0;
            bus.m1_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        bus.s_val   <= 1'b1;
                        bus.s_addr  <= pick_addr;
                        bus.s_write <= pick_write;
                        bus.s_wdata <= pick_wdata;
                        gnt         <= pick;
                        last        <= pick;
                        timer       <= 8'd0;
                        state       <= REQ;
                    end
                end

                // A slave response takes priority over a timeout that would
                // expire on the same edge.
                REQ: begin
                    if (bus.s_ready) begin
                        bus.s_val <= 1'b0;
                        state     <= DONE;
                        if (gnt) begin
                            bus.m1_rdata <= bus.s_rdata;
                            bus.m1_ready <= 1'b1;
                            bus.m1_err   <= 1'b0;
                        end else begin
                            bus.m0_rdata <= bus.s_rdata;
                            bus.m0_ready <= 1'b1;
                            bus.m0_err   <= 1'b0;
                        end
                    end else if (timer == TMO_LAST) begin
                        bus.s_val <= 1'b0;
                        state     <= DONE;
                        if (tmo_cnt != 16'hffff) begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
                        if (gnt) begin
                            bus.m1_rdata <= 32'hdead_dead;
                            bus.m1_ready <= 1'b1;
                            bus.m1_err   <= 1'b1;
                        end else begin
                            bus.m0_rdata <= 32'hdead_dead;
                            bus.m0_ready <= 1'b1;
                            bus.m0_err   <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                // One settling cycle: lets the slave drop its registered
                // ready and the winner drop its request.
                DONE: begin
                    bus.m0_rdata <= 32'd0;
                    bus.m0_ready <= 1'b0;
                    bus.m0_err   <= 1'b0;
                    bus.m1_rdata <= 32'd0;
                    bus.m1_ready <= 1'b0;
                    bus.m1_err   <= 1'b0;
                    state        <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regs_arb.sv
// tb_regs_arb: randomized self-checking bench for regs_arb. A transaction-level
// reference (round-robin winner choice, completion time derived from slave
// latency versus TIMEOUT, expected data and timeout count) predicts every
// observed output cycle by cycle.
module tb_regs_arb;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        busy;
    logic        gnt;
    logic [15:0] tmo_cnt;

    regs_arb_if #(.ADDR_W(ADDR_W)) bus ();

    regs_arb #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus    (bus),
        .busy   (busy),
        .gnt    (gnt),
        .tmo_cnt(tmo_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: pending request per requester, its fields, the last
    // winner and the number of timeouts seen since reset.
    logic              pend   [2];
    logic [ADDR_W-1:0] paddr  [2];
    logic              pwrite [2];
    logic [31:0]       pwdata [2];
    logic              lastM;
    int                tmoModel;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus();
        bus.m0_val   = pend[0];
        bus.m0_addr  = paddr[0];
        bus.m0_write = pwrite[0];
        bus.m0_wdata = pwdata[0];
        bus.m1_val   = pend[1];
        bus.m1_addr  = paddr[1];
        bus.m1_write = pwrite[1];
        bus.m1_wdata = pwdata[1];
    endtask

    task automatic setReq(input int n, input logic [ADDR_W-1:0] a, input logic w, input logic [31:0] d);
        pend[n]   = 1'b1;
        paddr[n]  = a;
        pwrite[n] = w;
        pwdata[n] = d;
    endtask

    task automatic newReq(input int n);
        setReq(n, ADDR_W'($urandom), 1'($urandom_range(0, 1)), $urandom);
    endtask

    function automatic logic [31:0] readyOf(input int n);
        return 32'(n == 1 ? bus.m1_ready : bus.m0_ready);
    endfunction

    function automatic logic [31:0] errOf(input int n);
        return 32'(n == 1 ? bus.m1_err : bus.m0_err);
    endfunction

    function automatic logic [31:0] rdataOf(input int n);
        return n == 1 ? bus.m1_rdata : bus.m0_rdata;
    endfunction

    task automatic checkQuiet(input string tag);
        checkOutput({tag, ".s_val"},    32'(bus.s_val),    32'd0);
        checkOutput({tag, ".busy"},     32'(busy),         32'd0);
        checkOutput({tag, ".m0_ready"}, 32'(bus.m0_ready), 32'd0);
        checkOutput({tag, ".m0_err"},   32'(bus.m0_err),   32'd0);
        checkOutput({tag, ".m0_rdata"}, bus.m0_rdata,      32'd0);
        checkOutput({tag, ".m1_ready"}, 32'(bus.m1_ready), 32'd0);
        checkOutput({tag, ".m1_err"},   32'(bus.m1_err),   32'd0);
        checkOutput({tag, ".m1_rdata"}, bus.m1_rdata,      32'd0);
        checkOutput({tag, ".tmo_cnt"},  32'(tmo_cnt),      32'(tmoModel));
    endtask

    // Called at the falling edge of an IDLE cycle with at least one request
    // pending; returns at the falling edge of the following IDLE cycle.
    // k: cycle (after s_val rises) in which the slave pulses ready.
    task automatic runTransaction(input string tag, input int k, input logic [31:0] resp);
        int                winner;
        int                other;
        int                expEnd;
        bit                timedOut;
        logic [ADDR_W-1:0] eAddr;
        logic              eWrite;
        logic [31:0]       eWdata;
        if (pend[0] && pend[1]) winner = lastM ? 0 : 1;
        else                    winner = pend[1] ? 1 : 0;
        other  = 1 - winner;
        eAddr  = paddr[winner];
        eWrite = pwrite[winner];
        eWdata = pwdata[winner];
        applyStimulus();
        @(negedge clk);
        lastM    = (winner == 1);
        timedOut = (k > TIMEOUT - 1);
        expEnd   = timedOut ? TIMEOUT + 1 : k + 2;
        for (int cyc = 1; cyc < expEnd; cyc++) begin
            checkOutput({tag, ".s_val"},   32'(bus.s_val),   32'd1);
            checkOutput({tag, ".s_addr"},  32'(bus.s_addr),  32'(eAddr));
            checkOutput({tag, ".s_write"}, 32'(bus.s_write), 32'(eWrite));
            checkOutput({tag, ".s_wdata"}, bus.s_wdata,      eWdata);
            checkOutput({tag, ".gnt"},     32'(gnt),         32'(winner));
            checkOutput({tag, ".busy"},    32'(busy),        32'd1);
            checkOutput({tag, ".ready_w"}, readyOf(winner),  32'd0);
            checkOutput({tag, ".ready_o"}, readyOf(other),   32'd0);
            bus.s_ready = (cyc == k + 1);
            bus.s_rdata = (cyc == k + 1) ? resp : $urandom;
            @(negedge clk);
        end
        bus.s_ready = (k == TIMEOUT);
        bus.s_rdata = $urandom;
        if (timedOut) tmoModel++;
        checkOutput({tag, ".done_s_val"}, 32'(bus.s_val),  32'd0);
        checkOutput({tag, ".done_busy"},  32'(busy),       32'd1);
        checkOutput({tag, ".done_gnt"},   32'(gnt),        32'(winner));
        checkOutput({tag, ".ready"},      readyOf(winner), 32'd1);
        checkOutput({tag, ".err"},        errOf(winner),   32'(timedOut));
        checkOutput({tag, ".rdata"},      rdataOf(winner), timedOut ? 32'hdead_dead : resp);
        checkOutput({tag, ".oth_ready"},  readyOf(other),  32'd0);
        checkOutput({tag, ".oth_err"},    errOf(other),    32'd0);
        checkOutput({tag, ".oth_rdata"},  rdataOf(other),  32'd0);
        checkOutput({tag, ".tmo_cnt"},    32'(tmo_cnt),    32'(tmoModel));
        pend[winner] = 1'b0;
        applyStimulus();
        @(negedge clk);
        bus.s_ready = (k == TIMEOUT + 1);
        checkQuiet({tag, ".idle"});
    endtask

    task automatic idleCycle();
        applyStimulus();
        @(negedge clk);
        bus.s_ready = 1'b0;
        checkOutput("idle.s_val", 32'(bus.s_val), 32'd0);
        checkOutput("idle.busy",  32'(busy),      32'd0);
    endtask

    task automatic midReset();
        while (pend[0] || pend[1]) runTransaction("drain", 1, $urandom);
        newReq(0);
        runTransaction("pre_rst", 2, $urandom);
        newReq(0);
        applyStimulus();
        @(negedge clk);
        bus.s_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        tmoModel = 0;
        lastM    = 1'b1;
        checkQuiet("rst");
        checkOutput("rst.gnt",     32'(gnt),         32'd0);
        checkOutput("rst.s_addr",  32'(bus.s_addr),  32'd0);
        checkOutput("rst.s_write", 32'(bus.s_write), 32'd0);
        checkOutput("rst.s_wdata", bus.s_wdata,      32'd0);
        @(negedge clk);
        checkQuiet("rst_hold");
        newReq(1);
        rstn = 1'b1;
        runTransaction("post_rst_tie", 1, $urandom);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int r;
        int k;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int n = 0; n < 2; n++) begin
            paddr[n]  = '0;
            pwrite[n] = 1'b0;
            pwdata[n] = 32'd0;
        end
        lastM       = 1'b1;
        tmoModel    = 0;
        bus.s_ready = 1'b0;
        bus.s_rdata = 32'd0;
        applyStimulus();
        repeat (3) @(negedge clk);
        checkQuiet("reset");
        checkOutput("reset.gnt", 32'(gnt), 32'd0);
        rstn = 1'b1;

        setReq(0, 10'h000, 1'b1, 32'h8000_1234);
        runTransaction("m0_write", 1, $urandom);

        setReq(1, 10'h104, 1'b0, 32'd0);
        runTransaction("m1_read", 1, 32'h0005_0003);

        newReq(0);
        newReq(1);
        for (int t = 0; t < 4; t++) begin
            if (!pend[0]) newReq(0);
            if (!pend[1]) newReq(1);
            runTransaction("contend", 1, $urandom);
        end
        while (pend[0] || pend[1]) runTransaction("drain", 1, $urandom);

        newReq(0);
        runTransaction("timeout_late_idle", TIMEOUT + 1, $urandom);
        newReq(0);
        runTransaction("timeout_late_done", TIMEOUT, $urandom);
        newReq(1);
        runTransaction("edge_ready", TIMEOUT - 1, $urandom);
        newReq(1);
        runTransaction("lat5", 5, $urandom);

        for (int t = 0; t < 150; t++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && $urandom_range(0, 1) == 1) newReq(n);
            end
            if (!pend[0] && !pend[1]) begin
                idleCycle();
            end else begin
                r = $urandom_range(0, 9);
                k = (r < 7) ? $urandom_range(1, 6) : TIMEOUT - 8 + r;
                runTransaction("rand", k, $urandom);
            end
        end

        midReset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
